fop_seq: RTL
============

FOP_SEQ -- requirements
Module: fop_seq

Interface
REQ-001 Parameter DATA_W, default 8, accumulator and immediate width (>=4).
REQ-002 Parameter ADDR_W, default 4, program address width; program depth = 2**ADDR_W words.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run gate; low freezes all execution state.
REQ-006 prog_we  input  1  program-memory write strobe.
REQ-007 prog_addr  input  ADDR_W  program write address.
REQ-008 prog_data  input  4+DATA_W  instruction word: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] imm.
REQ-009 acc  output  DATA_W  accumulator value.
REQ-010 pc  output  ADDR_W  program counter.
REQ-011 zero  output  1  high when acc == 0.
REQ-012 busy  output  1  high in FETCH or EXEC.
REQ-013 halted  output  1  high in HALT.
REQ-014 out_data  output  DATA_W  value captured by OUT.
REQ-015 out_valid  output  1  one-cycle pulse when out_data updates.

Function
REQ-016 States: IDLE, FETCH, EXEC, HALT; exactly one active.
REQ-017 IDLE -> FETCH when enable = 1; pc = 0 on entry.
REQ-018 FETCH: register mem[pc] into instruction register, -> EXEC; one cycle.
REQ-019 EXEC: execute the registered instruction, -> FETCH (or HALT); one cycle; every instruction costs exactly 2 enabled cycles.
REQ-020 enable = 0 in FETCH/EXEC/IDLE: state, pc, acc, instruction register hold; out_valid stays 0.
REQ-021 Opcodes: 0 NOP; 1 LDI acc=imm; 2 ADD acc=acc+imm; 3 SUB acc=acc-imm; 4 JMP pc=imm[ADDR_W-1:0]; 5 JZ jump if acc==0 else pc+1; 6 OUT out_data=acc; 7 HALT; 8-15 treated as NOP.
REQ-022 Non-jump instructions: pc = pc+1 modulo 2**ADDR_W; pc wraps from last address to 0.
REQ-023 JZ tests acc value at start of EXEC.
REQ-024 OUT: out_data and out_valid registered at the EXEC edge; out_valid high exactly the following cycle.
REQ-025 HALT: -> HALT, pc not incremented; HALT exits only by reset.
REQ-026 prog_we accepted only in IDLE or HALT; writes in FETCH/EXEC ignored.
REQ-027 prog_we in same cycle as IDLE->FETCH transition: write is accepted, FETCH of address 0 sees new data only if prog_addr != 0 or next cycle; write to address 0 on that edge is still performed.
REQ-028 Arithmetic unsigned DATA_W bits; without saturation wraps modulo 2**DATA_W.
REQ-029 zero is combinational from acc.

Reset
REQ-030 Reset asserted: state=IDLE, pc=0, acc=0, out_data=0, out_valid=0, instruction register=0 (NOP), immediately and asynchronously.
REQ-031 Program memory is not reset; contents survive reset.
REQ-032 Reset mid-instruction aborts it; no partial acc/pc/out update.

Configuration
REQ-033 Macro FOP_SEQ_SATURATE_EN defined: ADD clamps to 2**DATA_W-1 on overflow, SUB clamps to 0 on underflow.
REQ-034 Macro FOP_SEQ_SATURATE_EN undefined: ADD/SUB wrap modulo 2**DATA_W; no other behaviour changes.

Verification (DATA_W=8, ADDR_W=4)
REQ-035 Program {LDI 5, ADD 3, OUT, HALT}, enable=1 -> out_valid single pulse with out_data=8, halted=1 after 8 enabled cycles, pc=3.
REQ-036 Program {LDI 250, ADD 10, OUT, HALT} -> out_data=4 without macro, 255 with FOP_SEQ_SATURATE_EN; {LDI 2, SUB 5, OUT, HALT} -> 253 / 0.
REQ-037 Loop {LDI 3, SUB 1, JZ 4, JMP 1, OUT, HALT} -> single out_data=0 pulse, halted=1; enable toggled low 5 cycles mid-loop -> identical result, cycle count +5.
REQ-038 Program of 16 NOPs, enable=1 for 34 cycles -> pc wraps 15->0 and continues; busy stays 1.
REQ-039 Assert reset during EXEC of ADD with acc=7 -> acc=0, pc=0, IDLE, memory unchanged; rerun reproduces original output.
REQ-040 prog_we during busy to address 2 -> memory unchanged; same write in HALT -> read back by next run after reset.

Source files
------------

// File: rtl/fop_seq.sv
// ============================================================================
// Module   : fop_seq
// Brief    : Four-state accumulator sequencer running a small loadable program.
//            Optional macro FOP_SEQ_SATURATE_EN makes ADD/SUB saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fop_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [DATA_W+3:0]   prog_data,
    output logic [DATA_W-1:0]   acc,
    output logic [ADDR_W-1:0]   pc,
    output logic                zero,
    output logic                busy,
    output logic                halted,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid
);

    localparam int C_DEPTH = 1 << ADDR_W;

    localparam logic [3:0] C_OP_LDI  = 4'd1;
    localparam logic [3:0] C_OP_ADD  = 4'd2;
    localparam logic [3:0] C_OP_SUB  = 4'd3;
    localparam logic [3:0] C_OP_JMP  = 4'd4;
    localparam logic [3:0] C_OP_JZ   = 4'd5;
    localparam logic [3:0] C_OP_OUT  = 4'd6;
    localparam logic [3:0] C_OP_HALT = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [DATA_W-1:0]      acc_q, acc_d;
    logic [DATA_W+3:0]      ir_q, ir_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic [DATA_W+3:0]      mem [C_DEPTH];

    logic [3:0]             w_opcode;
    logic [DATA_W-1:0]      w_imm;
    logic [ADDR_W-1:0]      w_jmp_tgt;
    logic [DATA_W-1:0]      w_add_res;
    logic [DATA_W-1:0]      w_sub_res;
    logic                   w_mem_we;

    assign w_opcode  = ir_q[DATA_W+3:DATA_W];
    assign w_imm     = ir_q[DATA_W-1:0];
    assign w_jmp_tgt = ADDR_W'(w_imm);

`ifdef FOP_SEQ_SATURATE_EN
    logic [DATA_W:0]        w_sum;
    logic [DATA_W:0]        w_diff;

    assign w_sum     = {1'b0, acc_q} + {1'b0, w_imm};
    assign w_diff    = {1'b0, acc_q} - {1'b0, w_imm};
    // Carry out of the sum flags overflow; the borrow bit of the difference flags underflow.
    assign w_add_res = w_sum[DATA_W]  ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
    assign w_sub_res = w_diff[DATA_W] ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];
`else
    assign w_add_res = acc_q + w_imm;
    assign w_sub_res = acc_q - w_imm;
`endif

    // Program memory is loadable only while the core is not running, and is never reset.
    assign w_mem_we = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (enable) begin
                    ir_d    = mem[pc_q];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (enable) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + ADDR_W'(1);
                    case (w_opcode)
                        C_OP_LDI: acc_d = w_imm;
                        C_OP_ADD: acc_d = w_add_res;
                        C_OP_SUB: acc_d = w_sub_res;
                        C_OP_JMP: pc_d  = w_jmp_tgt;
                        C_OP_JZ: begin
                            if (acc_q == '0) begin
                                pc_d = w_jmp_tgt;
                            end
                        end
                        C_OP_OUT: begin
                            out_data_d  = acc_q;
                            out_valid_d = 1'b1;
                        end
                        C_OP_HALT: begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc       = acc_q;
    assign pc        = pc_q;
    assign zero      = (acc_q == '0);
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted    = (state_q == S_HALT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire
